// File: rtl/j1_io_hub.sv
// j1_io_hub: memory-mapped I/O hub between the J1 I/O bus and SLOTS peripheral slots.
// Define IO_HUB_ERR_CNT_EN to add the err_count / last_err_addr error tracking outputs.
module j1_io_hub #(
    parameter int          SLOTS          = 8,
    parameter int          SLOT_ADDR_BITS = 8,
    parameter logic [15:0] BASE_ADDR      = 16'h6000,
    parameter int          TIMEOUT        = 15,
    parameter logic [15:0] DEFAULT_DATA   = 16'h0666
) (
    input  logic                      sys_clk_i,
    input  logic                      sys_rst_n,
    input  logic                      io_rd,
    input  logic                      io_wr,
    input  logic [15:0]               io_addr,
    input  logic [15:0]               io_dout,
    output logic [15:0]               io_din,
    output logic                      io_stall,
    output logic [SLOT_ADDR_BITS-1:0] slv_addr,
    output logic [15:0]               slv_wdata,
    output logic [SLOTS-1:0]          slv_wr,
    output logic [SLOTS-1:0]          slv_rd,
    input  logic [16*SLOTS-1:0]       slv_rdata,
    input  logic [SLOTS-1:0]          slv_ack
`ifdef IO_HUB_ERR_CNT_EN
    ,
    output logic [15:0]               err_count,
    output logic [15:0]               last_err_addr
`endif
);

    localparam int          SW           = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int unsigned END_ADDR     = 32'(BASE_ADDR) + (32'(SLOTS) << SLOT_ADDR_BITS);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] READ_WAIT = 2'd1;
    localparam logic [1:0] DONE      = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [15:0]   addr_off;
    logic          hit;
    logic [SW-1:0] addr_slot;
    logic [SW-1:0] rd_slot;
    logic [SW+3:0] rd_lsb;
    logic [15:0]   wait_cnt;
    logic [15:0]   rd_data;
    logic          wr_accept;
    logic          wr_hit;
    logic          rd_start;
    logic          rd_ack;
    logic          rd_timeout;

    assign addr_off  = io_addr - BASE_ADDR;
    assign hit       = (io_addr >= BASE_ADDR) && (32'(io_addr) < END_ADDR);
    assign addr_slot = SW'(addr_off >> SLOT_ADDR_BITS);
    assign rd_lsb    = {rd_slot, 4'b0000};

    assign wr_accept  = io_wr && (state != READ_WAIT);
    assign wr_hit     = wr_accept && hit;
    assign rd_start   = (state == IDLE) && io_rd && !io_wr;
    assign rd_ack     = (state == READ_WAIT) && slv_ack[rd_slot];
    // The count reaches TIMEOUT on this cycle's increment; a same-cycle ack takes priority.
    assign rd_timeout = (state == READ_WAIT) && !slv_ack[rd_slot] && (wait_cnt == TIMEOUT_LAST);

    // Stall is gated by reset so J1 is released the moment reset asserts.
    assign io_stall = sys_rst_n && (rd_start || (state == READ_WAIT));
    assign io_din   = (state == DONE) ? rd_data : DEFAULT_DATA;
    assign slv_rd   = (state == READ_WAIT) ? (SLOTS'(1) << rd_slot) : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (rd_start) state_nxt = hit ? READ_WAIT : DONE;
            READ_WAIT: if (rd_ack || rd_timeout) state_nxt = DONE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            rd_slot  <= '0;
            wait_cnt <= '0;
            rd_data  <= DEFAULT_DATA;
        end else begin
            state <= state_nxt;
            if (rd_start) begin
                rd_slot  <= addr_slot;
                wait_cnt <= '0;
                rd_data  <= DEFAULT_DATA;
            end else if (state == READ_WAIT) begin
                wait_cnt <= wait_cnt + 16'd1;
                if (rd_ack) rd_data <= slv_rdata[rd_lsb +: 16];
            end
        end
    end

    // Posted write latch: one register stage decouples J1 from the slot fanout.
    always_ff @(posedge sys_clk_i or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            slv_wr    <= '0;
            slv_addr  <= '0;
            slv_wdata <= '0;
        end else begin
            slv_wr <= wr_hit ? (SLOTS'(1) << addr_slot) : '0;
            if (wr_hit) begin
                slv_addr  <= io_addr[SLOT_ADDR_BITS-1:0];
                slv_wdata <= io_dout;
            end else if (rd_start && hit) begin
                slv_addr <= io_addr[SLOT_ADDR_BITS-1:0];
            end
        end
    end

`ifdef IO_HUB_ERR_CNT_EN
    logic err_evt;

    assign err_evt = rd_timeout || (rd_start && !hit) || (wr_accept && !hit);

    always_ff @(posedge sys_clk_i or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            err_count     <= '0;
            last_err_addr <= '0;
        end else if (err_evt) begin
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            last_err_addr <= io_addr;
        end
    end
`endif

endmodule
